apb3_adc_regbank: RTL
=====================

// Module: apb3_adc_regbank
// PURPOSE
// Parametrised APB3 register bank for a multi-channel parallel ADC front end (AD7609-class and wider).
// Triggers conversions and snapshots all channels atomically on each ADC data-valid strobe.
// Supports one-shot and timer-paced continuous modes, with sticky DONE/OVERRUN/TIMEOUT flags, a
// sample counter and a level interrupt. Sits between the MSS APB3 fabric interface and the ADC
// interface controller.
// PARAMETERS
// NUM_CH    8      channels (1..64); channel n is read at offset 4*n
// DATA_W    16     ADC sample width (1..32)
// SIGN_EXT  1      1: sign-extend samples to 32 bits on read; 0: zero-extend
// TMO_CYC   100000 clk_i cycles allowed between start_o and adc_valid_i before timeout (>=2)
// PORTS
// clk_i       in   1              system clock
// rst_n_i     in   1              asynchronous, active-low reset
// PADDR       in   12             APB byte offset within the slot; bits [1:0] are ignored
// PSEL        in   1              APB select
// PENABLE     in   1              APB access phase
// PWRITE      in   1              1 = write
// PWDATA      in   32             write data
// PRDATA      out  32             read data
// PREADY      out  1              tied to 1 (zero wait states)
// PSLVERR     out  1              error response
// adc_data_i  in   NUM_CH*DATA_W  channel n at [n*DATA_W +: DATA_W]; valid only with adc_valid_i
// adc_valid_i in   1              one-cycle strobe: all channels are valid
// start_o     out  1              one-cycle conversion request to the ADC controller
// irq_o       out  1              registered level interrupt
// BEHAVIOUR
// Register map (byte offsets):
//   0x000+4n CHn   RO  last snapshot for channel n
//   0x100    CTRL  RW  [0] START (write-1 pulse, reads 0); [1] CONT; [2] IRQ_EN; [31:16] PERIOD
//   0x104    STAT  [0] DONE, [1] OVR, [2] TMO (sticky, W1C); [3] BUSY (RO)
//   0x108    SCNT  RO count of adc_valid_i, 32-bit, wraps 0xFFFFFFFF->0; any write clears to 0
// APB:
// - Writes take effect on the rising edge where PSEL&PENABLE&PWRITE.
// - PRDATA is a combinational mux of PADDR. It is valid during the access phase and is 0 when PSEL=0.
// - PSLVERR=1 in the access phase only, for: an unmapped offset; CHn with n>=NUM_CH; any write to a
//   CHn offset. Erroring writes have no side effect.
// Snapshot:
// - On adc_valid_i, all NUM_CH registers update in the same cycle, so reads are never torn.
// - SCNT increments on the same edge.
// - If DONE is already 1 when adc_valid_i arrives, OVR is set. Data is still overwritten.
// FSM IDLE/TRIG/WAIT (BUSY = state!=IDLE):
// - IDLE->TRIG when START is written 1, or when CONT=1 and the period counter reaches 0.
// - TRIG drives start_o=1 for exactly one cycle, then goes to WAIT and loads the timeout counter
//   with TMO_CYC.
// - WAIT->IDLE on adc_valid_i (sets DONE).
// - WAIT->IDLE on timeout expiry (sets TMO; no snapshot).
// - START written while BUSY is ignored.
// - adc_valid_i while IDLE/TRIG still snapshots, counts and updates DONE/OVR.
// Period counter:
// - Loaded with PERIOD on entry to IDLE and decremented each IDLE cycle while CONT=1.
// - PERIOD=0 retriggers on the cycle after IDLE entry.
// - Clearing CONT during WAIT lets the current conversion finish; no further triggers follow.
// Flag priority:
// - A hardware set wins over a same-cycle W1C of the same bit.
// - An SCNT clear-write in the same cycle as adc_valid_i yields SCNT=1.
// irq_o is registered: irq_o <= IRQ_EN & (DONE|OVR|TMO); it deasserts one cycle after the flags
// are cleared.
// Reset (async, any state): FSM=IDLE; start_o=0; irq_o=0; all CHn, CTRL, STAT and SCNT = 0.
// An in-flight conversion is abandoned.
// TESTING
// T1 One-shot: write CTRL=0x1; adc_valid_i with CH0=0x8001 -> one start_o pulse;
//    CH0 reads 0xFFFF8001 (SIGN_EXT=1); STAT=0x1; SCNT=1.
// T2 Continuous: CTRL=0x0003_0002 -> start_o pulses repeat with 3 IDLE cycles between WAIT exit
//    and the next TRIG. Clear CONT mid-WAIT -> no pulse after that conversion completes.
// T3 Overrun/IRQ: IRQ_EN=1; two adc_valid_i with no STAT clear -> STAT=0x3; irq_o=1.
//    Write STAT=0x3 -> irq_o=0 one cycle later.
// T4 Timeout: TMO_CYC=16; START with no adc_valid_i -> TMO set 16 cycles after WAIT entry;
//    BUSY=0; snapshots unchanged.
// T5 Errors: read CHn with n=NUM_CH, read 0x10C, write 0x000 -> PSLVERR=1 and no state change.
//    START written while BUSY -> ignored.
// T6 Collisions/reset: W1C of DONE on the same edge as adc_valid_i -> DONE stays 1.
//    rst_n_i low during WAIT -> all outputs and registers 0; the FSM idles after release.

Source files
------------

// File: rtl/apb3_adc_regbank.sv
// APB3 register bank for a multi-channel parallel ADC: trigger FSM, atomic channel snapshots,
// sticky status flags, sample counter and a registered level interrupt.
module apb3_adc_regbank #(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 16,
  parameter int SIGN_EXT = 1,
  parameter int TMO_CYC  = 100000
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [11:0]              PADDR,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PWDATA,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic [NUM_CH*DATA_W-1:0] adc_data_i,
  input  logic                     adc_valid_i,
  output logic                     start_o,
  output logic                     irq_o
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_r, state_n_s;
  logic [DATA_W-1:0] ch_r [NUM_CH];
  logic              cont_r, irq_en_r;
  logic [15:0]       period_r, per_cnt_r;
  logic              done_r, ovr_r, tmo_r;
  logic [31:0]       scnt_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic              start_r, irq_r;
  logic              tmo_hit_s;

  function automatic logic [31:0] ext_f(input logic [DATA_W-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[DATA_W-1:0] = v;
    if ((SIGN_EXT != 0) && v[DATA_W-1]) begin
      for (int i = DATA_W; i < 32; i++) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Address decode; byte-lane bits and unused write-data bits are deliberately ignored
  logic [9:0] word_s;
  logic [5:0] ch_idx_s;
  logic       is_ch_s, ch_ok_s, is_ctrl_s, is_stat_s, is_scnt_s, err_s;
  logic       access_s, wr_s, ctrl_wr_s, stat_wr_s, scnt_wr_s, start_req_s, busy_s;
  logic       addr_unused_s;

  assign word_s        = PADDR[11:2];
  assign addr_unused_s = ^{PADDR[1:0], PWDATA[15:3]};
  assign ch_idx_s      = word_s[5:0];
  assign is_ch_s       = (word_s[9:6] == 4'd0);
  assign ch_ok_s       = is_ch_s && ({26'd0, ch_idx_s} < 32'(NUM_CH));
  assign is_ctrl_s     = (word_s == 10'h040);
  assign is_stat_s     = (word_s == 10'h041);
  assign is_scnt_s     = (word_s == 10'h042);
  assign err_s         = (is_ch_s && (!ch_ok_s || PWRITE)) ||
                         (!is_ch_s && !is_ctrl_s && !is_stat_s && !is_scnt_s);
  assign access_s      = PSEL & PENABLE;
  assign wr_s          = access_s & PWRITE & ~err_s;
  assign ctrl_wr_s     = wr_s & is_ctrl_s;
  assign stat_wr_s     = wr_s & is_stat_s;
  assign scnt_wr_s     = wr_s & is_scnt_s;
  assign start_req_s   = ctrl_wr_s & PWDATA[0];
  assign busy_s        = (state_r != ST_IDLE);

  assign PREADY  = 1'b1;
  assign PSLVERR = access_s & err_s;
  assign start_o = start_r;
  assign irq_o   = irq_r;

  // Combinational read mux
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL) begin
      if (is_ctrl_s) begin
        PRDATA = {period_r, 13'd0, irq_en_r, cont_r, 1'b0};
      end else if (is_stat_s) begin
        PRDATA = {28'd0, busy_s, tmo_r, ovr_r, done_r};
      end else if (is_scnt_s) begin
        PRDATA = scnt_r;
      end else if (ch_ok_s) begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (ch_idx_s == 6'(n)) PRDATA = ext_f(ch_r[n]);
        end
      end else begin
        PRDATA = 32'd0;
      end
    end else begin
      PRDATA = 32'd0;
    end
  end

  // Trigger FSM next state; a data-valid in WAIT takes precedence over a same-cycle timeout
  always_comb begin
    state_n_s = state_r;
    tmo_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_req_s || (cont_r && (per_cnt_r <= 16'd1))) state_n_s = ST_TRIG;
        else                                                  state_n_s = ST_IDLE;
      end
      ST_TRIG: state_n_s = ST_WAIT;
      ST_WAIT: begin
        if (adc_valid_i) begin
          state_n_s = ST_IDLE;
        end else if (tmo_cnt_r == TMO_W'(1)) begin
          state_n_s = ST_IDLE;
          tmo_hit_s = 1'b1;
        end else begin
          state_n_s = ST_WAIT;
        end
      end
      default: state_n_s = ST_IDLE;
    endcase
  end

  // FSM state, start pulse and timeout counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= ST_IDLE;
      start_r   <= 1'b0;
      tmo_cnt_r <= '0;
    end else begin
      state_r <= state_n_s;
      start_r <= (state_n_s == ST_TRIG);
      if (state_r == ST_TRIG)                              tmo_cnt_r <= TMO_W'(TMO_CYC);
      else if ((state_r == ST_WAIT) && (tmo_cnt_r != '0))  tmo_cnt_r <= tmo_cnt_r - TMO_W'(1);
      else                                                 tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Period counter: reloaded on IDLE entry (or a CTRL write in IDLE), counts down while CONT=1
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      per_cnt_r <= 16'd0;
    end else if ((state_r != ST_IDLE) && (state_n_s == ST_IDLE)) begin
      per_cnt_r <= period_r;
    end else if ((state_r == ST_IDLE) && ctrl_wr_s) begin
      per_cnt_r <= PWDATA[31:16];
    end else if ((state_r == ST_IDLE) && cont_r && (per_cnt_r != 16'd0)) begin
      per_cnt_r <= per_cnt_r - 16'd1;
    end else begin
      per_cnt_r <= per_cnt_r;
    end
  end

  // Control register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cont_r   <= 1'b0;
      irq_en_r <= 1'b0;
      period_r <= 16'd0;
    end else if (ctrl_wr_s) begin
      cont_r   <= PWDATA[1];
      irq_en_r <= PWDATA[2];
      period_r <= PWDATA[31:16];
    end
  end

  // Sticky flags: a hardware set beats a same-cycle W1C
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
      tmo_r  <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      done_r <= adc_valid_i | (done_r & ~(stat_wr_s & PWDATA[0]));
      ovr_r  <= (adc_valid_i & done_r) | (ovr_r & ~(stat_wr_s & PWDATA[1]));
      tmo_r  <= tmo_hit_s | (tmo_r & ~(stat_wr_s & PWDATA[2]));
      irq_r  <= irq_en_r & (done_r | ovr_r | tmo_r);
    end
  end

  // Sample counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)         scnt_r <= 32'd0;
    else if (adc_valid_i) scnt_r <= scnt_wr_s ? 32'd1 : scnt_r + 32'd1;
    else if (scnt_wr_s)   scnt_r <= 32'd0;
    else                  scnt_r <= scnt_r;
  end

  // Atomic snapshot of every channel
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < NUM_CH; n++) ch_r[n] <= '0;
    end else if (adc_valid_i) begin
      for (int n = 0; n < NUM_CH; n++) ch_r[n] <= adc_data_i[n*DATA_W +: DATA_W];
    end
  end

endmodule
